fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
Instruction-fetch sequencer for the MIPS core. It drives the program counter register's load address and load enable, and runs the instruction-memory request/acknowledge handshake. It applies redirects (branch/jump, exception, eret) with fixed priority, discards stale fetches after a redirect, and presents fetched instructions to decode through a one-entry output buffer that honours stall.

Parameters:
BOOT_ADDR, 32'h0000_3000, first fetch address after reset
EXC_VEC, 32'h0000_4180, exception entry address
TMO_W, 8, width of the fetch-timeout counter (optional feature only)

Ports:
CLK  in  1  clock, all state on rising edge
RST  in  1  reset, asynchronous, active-low
pc_i  in  32  current PC register value
pc_next_o  out  32  load value for the PC register
pc_en_o  out  1  PC register load enable
imem_req_o  out  1  fetch request, single-cycle pulse
imem_addr_o  out  32  fetch address, equal to pc_i while imem_req_o is high
imem_ack_i  in  1  fetch complete; arrives at least 1 cycle after the request
imem_rdata_i  in  32  instruction word, valid with imem_ack_i
redir_valid_i  in  1  branch/jump redirect pulse
redir_addr_i  in  32  redirect target
exc_i  in  1  exception pulse
exc_pc_i  in  32  faulting PC, captured into EPC
eret_i  in  1  return from exception
stall_i  in  1  decode cannot accept an instruction this cycle
inst_valid_o  out  1  output buffer holds an instruction
inst_o  out  32  buffered instruction
inst_pc_o  out  32  address of the buffered instruction
epc_o  out  32  exception PC register
err_o  out  1  fetch-timeout error pulse (optional feature)

Behaviour:
- Reset (RST low, asynchronous): state is BOOT. All outputs are 0: inst_valid_o, inst_o, inst_pc_o, epc_o, imem_req_o, pc_en_o, pc_next_o, err_o.
- The FSM has four states: BOOT, FETCH, WAIT, DISCARD.
- BOOT: drive pc_en_o=1 and pc_next_o=BOOT_ADDR for exactly one cycle, then go to FETCH. Redirect inputs are ignored in BOOT.
- FETCH:
  - Issue a request when the buffer is free: inst_valid_o=0, or inst_valid_o=1 with stall_i=0.
  - On a request, drive imem_req_o=1 and imem_addr_o=pc_i, then go to WAIT.
  - Otherwise hold in FETCH.
- WAIT, on imem_ack_i:
  - Load the buffer: inst_o=imem_rdata_i, inst_pc_o=pc_i, inst_valid_o=1 on the next edge.
  - Drive pc_en_o=1 and pc_next_o=pc_i+4, then go to FETCH.
  - pc_i+4 wraps modulo 2^32.
- Redirect sources, highest priority first: exc_i, then eret_i, then redir_valid_i.
  - Targets are EXC_VEC, epc_o and redir_addr_i respectively.
  - An exception also loads epc_o with exc_pc_i on the same edge.
  - Any redirect drives pc_en_o=1 and pc_next_o=target. It suppresses imem_req_o that cycle and clears the buffer (inst_valid_o=0 next cycle).
  - A redirect in FETCH stays in FETCH.
  - A redirect in WAIT without an ack goes to DISCARD.
  - A redirect in WAIT with an ack in the same cycle drops the returned word (buffer not loaded) and goes to FETCH.
  - A redirect in DISCARD updates the PC and stays in DISCARD.
- DISCARD: wait for imem_ack_i, drop the data without loading the buffer, then go to FETCH. The PC is not advanced.
- Buffer:
  - Consumed at an edge where inst_valid_o=1 and stall_i=0.
  - Cleared on consume unless it is reloaded by an ack on the same edge.
  - While stall_i=1, inst_o and inst_pc_o hold.
- pc_en_o is asserted in at most one cycle per transition. It is never asserted in FETCH or WAIT without a redirect or ack.
- At most one request is outstanding at any time.

Optional Feature:
FETCH_TIMEOUT_EN
- Defined:
  - A TMO_W-bit counter clears on each request and increments every WAIT or DISCARD cycle without an ack.
  - When it reaches all-ones, pulse err_o for 1 cycle, treat the event as an exception (epc_o=pc_i, target EXC_VEC) and go to FETCH.
  - A late ack arriving after the timeout is ignored. Any ack received while in FETCH is dropped.
- Undefined: no counter is built, err_o is tied to 0, and WAIT/DISCARD wait indefinitely.

Test Plan:
- Reset release, ack 1 cycle after each request -> pc_en_o with 32'h3000 in cycle 1; requests to 3000, 3004, 3008; inst_pc_o follows the same sequence.
- stall_i held high 5 cycles with the buffer full -> inst_o and inst_valid_o stable; no imem_req_o; exactly one request after stall_i falls.
- redir_valid_i to 32'h3100 in WAIT, ack 3 cycles later -> that word is never made valid; next request addr=32'h3100.
- exc_i with exc_pc_i=32'h3010 together with redir_valid_i -> pc_next_o=32'h4180, epc_o=32'h3010; eret_i later -> next fetch at 32'h3010.
- RST asserted low while in WAIT -> all outputs 0 immediately; after release the BOOT sequence repeats; a late ack is ignored.
- With FETCH_TIMEOUT_EN, TMO_W=8, no ack -> err_o pulses 255 cycles after the request; next request to 32'h4180; epc_o = stalled PC.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: drives PC load, runs the imem req/ack handshake,
// applies redirects and buffers one fetched word. Optional macro: FETCH_TIMEOUT_EN.
module fetch_ctrl #(
    parameter logic [31:0] BOOT_ADDR = 32'h0000_3000,
    parameter logic [31:0] EXC_VEC   = 32'h0000_4180,
    parameter int          TMO_W     = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] pc_i,
    output logic [31:0] pc_next_o,
    output logic        pc_en_o,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redir_valid_i,
    input  logic [31:0] redir_addr_i,
    input  logic        exc_i,
    input  logic [31:0] exc_pc_i,
    input  logic        eret_i,
    input  logic        stall_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    output logic [31:0] epc_o,
    output logic        err_o
);

    typedef enum logic [1:0] {S_BOOT, S_FETCH, S_WAIT, S_DISCARD} state_t;

    state_t      state;
    logic        in_flight;
    logic        tmo_hit;
    logic        exc_take;
    logic        redir_any;
    logic        buf_free;
    logic        req_issue;
    logic [31:0] redir_tgt;

    assign in_flight = (state == S_WAIT) || (state == S_DISCARD);
    assign exc_take  = exc_i || tmo_hit;
    assign redir_any = exc_take || eret_i || redir_valid_i;
    assign buf_free  = !inst_valid_o || !stall_i;
    assign req_issue = (state == S_FETCH) && !redir_any && buf_free;

    // The PC is only reloaded after the request edge, so the address is pc_i as seen now.
    assign imem_addr_o = pc_i;

    always_comb begin
        redir_tgt = redir_addr_i;
        if (exc_take)
            redir_tgt = EXC_VEC;
        else if (eret_i)
            redir_tgt = epc_o;
    end

`ifdef FETCH_TIMEOUT_EN
    localparam logic [TMO_W-1:0] TMO_LAST = ~TMO_W'(1);

    logic [TMO_W-1:0] tmo_cnt;

    // Fires on the cycle the counter would step to all-ones.
    assign tmo_hit = in_flight && !imem_ack_i && (tmo_cnt == TMO_LAST);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            tmo_cnt <= '0;
            err_o   <= 1'b0;
        end else begin
            err_o <= tmo_hit;
            if (req_issue)
                tmo_cnt <= '0;
            else if (in_flight && !imem_ack_i && !tmo_hit)
                tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`else
    logic [31:0] unused_tmo_w;
    assign unused_tmo_w = TMO_W;
    assign tmo_hit      = 1'b0;
    assign err_o        = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state        <= S_BOOT;
            pc_next_o    <= '0;
            pc_en_o      <= 1'b0;
            imem_req_o   <= 1'b0;
            inst_valid_o <= 1'b0;
            inst_o       <= '0;
            inst_pc_o    <= '0;
            epc_o        <= '0;
        end else begin
            pc_en_o    <= 1'b0;
            imem_req_o <= 1'b0;
            if (inst_valid_o && !stall_i)
                inst_valid_o <= 1'b0;

            if (state == S_BOOT) begin
                pc_en_o   <= 1'b1;
                pc_next_o <= BOOT_ADDR;
                state     <= S_FETCH;
            end else if (redir_any) begin
                pc_en_o      <= 1'b1;
                pc_next_o    <= redir_tgt;
                inst_valid_o <= 1'b0;
                if (exc_take)
                    epc_o <= exc_i ? exc_pc_i : pc_i;
                // An ack this cycle retires the outstanding fetch; otherwise drain it.
                if (in_flight)
                    state <= (imem_ack_i || tmo_hit) ? S_FETCH : S_DISCARD;
            end else begin
                case (state)
                    S_FETCH: begin
                        if (req_issue) begin
                            imem_req_o <= 1'b1;
                            state      <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (imem_ack_i) begin
                            inst_valid_o <= 1'b1;
                            inst_o       <= imem_rdata_i;
                            inst_pc_o    <= pc_i;
                            pc_en_o      <= 1'b1;
                            pc_next_o    <= pc_i + 32'd4;
                            state        <= S_FETCH;
                        end
                    end
                    S_DISCARD: begin
                        if (imem_ack_i)
                            state <= S_FETCH;
                    end
                    default: state <= S_BOOT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: boot sequence, stall, redirect, wrap,
// exception/eret priority and asynchronous reset mid-fetch.
module tb_fetch_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [31:0] pc_i;
    logic [31:0] pc_next_o;
    logic        pc_en_o;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic        redir_valid_i;
    logic [31:0] redir_addr_i;
    logic        exc_i;
    logic [31:0] exc_pc_i;
    logic        eret_i;
    logic        stall_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic [31:0] epc_o;
    logic        err_o;

    int          n_chk   = 0;
    int          n_err   = 0;
    int          ack_dly = 1;
    logic [31:0] req_log[$];
    logic [31:0] cons_pc[$];
    logic [31:0] cons_dat[$];

    fetch_ctrl dut (
        .CLK          (CLK),
        .RST          (RST),
        .pc_i         (pc_i),
        .pc_next_o    (pc_next_o),
        .pc_en_o      (pc_en_o),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_ack_i   (imem_ack_i),
        .imem_rdata_i (imem_rdata_i),
        .redir_valid_i(redir_valid_i),
        .redir_addr_i (redir_addr_i),
        .exc_i        (exc_i),
        .exc_pc_i     (exc_pc_i),
        .eret_i       (eret_i),
        .stall_i      (stall_i),
        .inst_valid_o (inst_valid_o),
        .inst_o       (inst_o),
        .inst_pc_o    (inst_pc_o),
        .epc_o        (epc_o),
        .err_o        (err_o)
    );

    always #5 CLK = ~CLK;

    // PC register owned by the surrounding core.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            pc_i <= '0;
        else if (pc_en_o)
            pc_i <= pc_next_o;
    end

    // Instruction memory: returns ~addr, ack_dly cycles after the request.
    initial begin
        logic [31:0] a;
        imem_ack_i   = 1'b0;
        imem_rdata_i = '0;
        forever begin
            @(negedge CLK);
            #2;
            if (RST && imem_req_o) begin
                a = imem_addr_o;
                req_log.push_back(a);
                repeat (ack_dly) @(negedge CLK);
                #2;
                imem_ack_i   = 1'b1;
                imem_rdata_i = ~a;
                @(negedge CLK);
                imem_ack_i   = 1'b0;
                imem_rdata_i = '0;
            end
        end
    end

    // Records every word decode takes out of the buffer.
    initial begin
        forever begin
            @(negedge CLK);
            #2;
            if (RST && inst_valid_o && !stall_i) begin
                cons_pc.push_back(inst_pc_o);
                cons_dat.push_back(inst_o);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_req();
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(negedge CLK);
            hit = imem_req_o;
        end
        chk("req_seen", {31'b0, hit}, 32'd1);
    endtask

    task automatic clear_logs();
        req_log.delete();
        cons_pc.delete();
        cons_dat.delete();
    endtask

    initial begin
        logic [31:0] exp_pc;
        int          nreq0;

        redir_valid_i = 1'b0;
        redir_addr_i  = '0;
        exc_i         = 1'b0;
        exc_pc_i      = '0;
        eret_i        = 1'b0;
        stall_i       = 1'b0;

        // reset state
        repeat (3) @(negedge CLK);
        chk("rst_pc_next", pc_next_o, 32'h0);
        chk("rst_pc_en", {31'b0, pc_en_o}, 32'h0);
        chk("rst_req", {31'b0, imem_req_o}, 32'h0);
        chk("rst_valid", {31'b0, inst_valid_o}, 32'h0);
        chk("rst_inst", inst_o, 32'h0);
        chk("rst_inst_pc", inst_pc_o, 32'h0);
        chk("rst_epc", epc_o, 32'h0);
        chk("rst_err", {31'b0, err_o}, 32'h0);

        // boot and sequential fetch, ack one cycle after each request
        RST = 1'b1;
        @(negedge CLK);
        chk("boot_pc_en", {31'b0, pc_en_o}, 32'h1);
        chk("boot_pc_next", pc_next_o, 32'h0000_3000);
        chk("boot_no_req", {31'b0, imem_req_o}, 32'h0);
        @(negedge CLK);
        chk("req0", {31'b0, imem_req_o}, 32'h1);
        chk("req0_addr", imem_addr_o, 32'h0000_3000);
        chk("req0_pc_en", {31'b0, pc_en_o}, 32'h0);
        repeat (14) @(negedge CLK);
        #3;
        chk("seq_req0", req_log[0], 32'h0000_3000);
        chk("seq_req1", req_log[1], 32'h0000_3004);
        chk("seq_req2", req_log[2], 32'h0000_3008);
        chk("seq_pc0", cons_pc[0], 32'h0000_3000);
        chk("seq_pc1", cons_pc[1], 32'h0000_3004);
        chk("seq_pc2", cons_pc[2], 32'h0000_3008);
        chk("seq_dat0", cons_dat[0], 32'hFFFF_CFFF);
        chk("seq_dat2", cons_dat[2], 32'hFFFF_CFF7);

        // stall with the buffer full
        begin
            logic hit;
            hit = 1'b0;
            for (int i = 0; i < 20 && !hit; i++) begin
                @(negedge CLK);
                hit = inst_valid_o;
            end
            chk("valid_seen", {31'b0, hit}, 32'd1);
        end
        stall_i = 1'b1;
        #3;
        exp_pc = req_log[$];
        nreq0  = req_log.size();
        ack_dly = 3;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk("stall_valid", {31'b0, inst_valid_o}, 32'h1);
            chk("stall_inst_pc", inst_pc_o, exp_pc);
            chk("stall_inst", inst_o, ~exp_pc);
        end
        #3;
        chk("stall_no_req", req_log.size(), nreq0);
        @(negedge CLK);
        stall_i = 1'b0;
        repeat (3) @(negedge CLK);
        #3;
        chk("unstall_one_req", req_log.size(), nreq0 + 1);

        // branch redirect while a fetch is outstanding
        wait_req();
        clear_logs();
        redir_valid_i = 1'b1;
        redir_addr_i  = 32'h0000_3100;
        @(negedge CLK);
        redir_valid_i = 1'b0;
        chk("redir_pc_en", {31'b0, pc_en_o}, 32'h1);
        chk("redir_pc_next", pc_next_o, 32'h0000_3100);
        chk("redir_valid_clr", {31'b0, inst_valid_o}, 32'h0);
        repeat (12) @(negedge CLK);
        #3;
        chk("redir_next_req", req_log[1], 32'h0000_3100);
        chk("redir_first_pc", cons_pc[0], 32'h0000_3100);
        chk("redir_first_dat", cons_dat[0], 32'hFFFF_CEFF);

        // PC increment wraps at the top of the address space
        wait_req();
        clear_logs();
        redir_valid_i = 1'b1;
        redir_addr_i  = 32'hFFFF_FFFC;
        @(negedge CLK);
        redir_valid_i = 1'b0;
        repeat (14) @(negedge CLK);
        #3;
        chk("wrap_req_top", req_log[1], 32'hFFFF_FFFC);
        chk("wrap_req_zero", req_log[2], 32'h0000_0000);

        // exception beats a simultaneous branch; eret returns to EPC
        wait_req();
        clear_logs();
        exc_i         = 1'b1;
        exc_pc_i      = 32'h0000_3010;
        redir_valid_i = 1'b1;
        redir_addr_i  = 32'h0000_5000;
        @(negedge CLK);
        exc_i         = 1'b0;
        redir_valid_i = 1'b0;
        chk("exc_pc_en", {31'b0, pc_en_o}, 32'h1);
        chk("exc_pc_next", pc_next_o, 32'h0000_4180);
        chk("exc_epc", epc_o, 32'h0000_3010);
        repeat (10) @(negedge CLK);
        #3;
        chk("exc_next_req", req_log[1], 32'h0000_4180);
        wait_req();
        clear_logs();
        eret_i = 1'b1;
        @(negedge CLK);
        eret_i = 1'b0;
        chk("eret_pc_next", pc_next_o, 32'h0000_3010);
        repeat (10) @(negedge CLK);
        #3;
        chk("eret_next_req", req_log[1], 32'h0000_3010);
        chk("eret_epc_hold", epc_o, 32'h0000_3010);

        // asynchronous reset while waiting on a fetch; its ack lands in reset
        wait_req();
        RST = 1'b0;
        #1;
        chk("arst_req", {31'b0, imem_req_o}, 32'h0);
        chk("arst_epc", epc_o, 32'h0);
        chk("arst_pc_next", pc_next_o, 32'h0);
        chk("arst_inst_pc", inst_pc_o, 32'h0);
        chk("arst_inst", inst_o, 32'h0);
        chk("arst_valid", {31'b0, inst_valid_o}, 32'h0);
        repeat (6) @(negedge CLK);
        clear_logs();
        RST = 1'b1;
        @(negedge CLK);
        chk("reboot_pc_en", {31'b0, pc_en_o}, 32'h1);
        chk("reboot_pc_next", pc_next_o, 32'h0000_3000);
        @(negedge CLK);
        chk("reboot_req", {31'b0, imem_req_o}, 32'h1);
        chk("reboot_addr", imem_addr_o, 32'h0000_3000);
        repeat (12) @(negedge CLK);
        #3;
        chk("reboot_req1", req_log[1], 32'h0000_3004);
        chk("reboot_pc0", cons_pc[0], 32'h0000_3000);
        chk("reboot_dat0", cons_dat[0], 32'hFFFF_CFFF);
        chk("reboot_err", {31'b0, err_o}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
